// File: rtl/serial_parity_pkg.sv
// Shared definitions for the serial parity link: receive FSM encoding and
// parity-sense constants (also used by the transmit-side generator).
package serial_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/parity_accum.sv
// Single-bit running XOR with load (start a new frame), enable (fold in a bit)
// and clear; sequential counterpart of the combinational parity generator.
module parity_accum (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic en,
  input  logic din,
  output logic parity
);

  logic parity_q;
  logic parity_d;

  always_comb begin
    parity_d = parity_q;
    if (load) begin
      parity_d = din;
    end else if (en) begin
      parity_d = parity_q ^ din;
    end else if (clr) begin
      parity_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Receive side of the serial parity link: deserializes MSB-first frames,
// checks the trailing parity bit and reports each word with error flags.
module serial_parity_checker
  import serial_parity_pkg::*;
#(
  parameter int   DATA_BITS  = 3,
  parameter logic ODD_PARITY = PARITY_EVEN,
  parameter int   ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 in_sof,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic acc_clr, acc_load, acc_en, acc_parity;
  logic sof_beat, data_beat, frame_bad;

  assign sof_beat  = in_valid & in_sof;
  assign data_beat = in_valid & ~in_sof;
  assign frame_bad = acc_parity ^ in_bit ^ ODD_PARITY;

  parity_accum u_parity_accum (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .load   (acc_load),
    .en     (acc_en),
    .din    (in_bit),
    .parity (acc_parity)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = 1'b0;
    err_count_d  = err_count_q;
    acc_clr      = 1'b0;
    acc_load     = 1'b0;
    acc_en       = 1'b0;

    // A sof beat always starts a fresh frame; outside IDLE it also abandons one.
    if (sof_beat) begin
      frame_err_d = (state_q != IDLE);
      shift_d     = {{(DATA_BITS-1){1'b0}}, in_bit};
      bit_cnt_d   = CNT_W'(1);
      acc_load    = 1'b1;
      state_d     = (DATA_BITS == 1) ? PARITY : DATA;
    end else if (data_beat) begin
      case (state_q)
        DATA: begin
          shift_d   = {shift_q[DATA_BITS-2:0], in_bit};
          bit_cnt_d = bit_cnt_q + 1'b1;
          acc_en    = 1'b1;
          if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          out_valid_d  = 1'b1;
          out_data_d   = shift_q;
          parity_err_d = frame_bad;
          if (frame_bad && (err_count_q != {ERR_CNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
          end
          acc_clr = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign err_count  = err_count_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: even and odd instances share one stimulus
// stream; expectations come from whole-frame XOR arithmetic.
module tb_serial_parity_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic in_sof = 1'b0;

  logic       ov_e, pe_e, fe_e, busy_e;
  logic [2:0] od_e;
  logic [7:0] cnt_e;
  logic       ov_o, pe_o, fe_o, busy_o;
  logic [2:0] od_o;
  logic [7:0] cnt_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference state
  int         m_cnt_e, m_cnt_o;
  logic [2:0] m_data;
  logic       m_err_e, m_err_o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_parity_checker #(.DATA_BITS(3), .ODD_PARITY(1'b0), .ERR_CNT_W(8)) dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
    .out_valid(ov_e), .out_data(od_e), .parity_err(pe_e), .frame_err(fe_e),
    .busy(busy_e), .err_count(cnt_e)
  );

  serial_parity_checker #(.DATA_BITS(3), .ODD_PARITY(1'b1), .ERR_CNT_W(8)) dut_o (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
    .out_valid(ov_o), .out_data(od_o), .parity_err(pe_o), .frame_err(fe_o),
    .busy(busy_o), .err_count(cnt_o)
  );

  // One clock of input: drive on the falling edge, return 1 time unit after the rise.
  task automatic step(input logic v, input logic b, input logic s);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    in_sof   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'($urandom));
  endtask

  // A completed frame: XOR over data and parity decides both senses.
  task automatic model_frame(input logic [2:0] d, input logic p);
    m_data  = d;
    m_err_e = ^{d, p};
    m_err_o = ~m_err_e;
    if (m_err_e && m_cnt_e < 255) m_cnt_e++;
    if (m_err_o && m_cnt_o < 255) m_cnt_o++;
  endtask

  task automatic send_frame(input logic [2:0] d, input logic p, input int gap,
                            output logic fe_at_sof);
    step(1'b1, d[2], 1'b1);
    fe_at_sof = fe_e;
    idle(gap);
    step(1'b1, d[1], 1'b0);
    idle(gap);
    step(1'b1, d[0], 1'b0);
    idle(gap);
    step(1'b1, p, 1'b0);
    model_frame(d, p);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({ov_e, od_e, pe_e, fe_e, busy_e, cnt_e} !== 15'd0) begin
      errors++; $display("FAIL reset_even got %h want 0", {ov_e, od_e, pe_e, fe_e, busy_e, cnt_e});
    end
    checks++; if ({ov_o, od_o, pe_o, fe_o, busy_o, cnt_o} !== 15'd0) begin
      errors++; $display("FAIL reset_odd got %h want 0", {ov_o, od_o, pe_o, fe_o, busy_o, cnt_o});
    end
    @(negedge clk);
    rst = 1'b0;
    m_cnt_e = 0;
    m_cnt_o = 0;
    $display("reset: released");
  endtask

  task automatic test_good;
    logic fe;
    send_frame(3'b101, 1'b0, 0, fe);
    checks++; if ({ov_e, od_e, pe_e, cnt_e} !== {1'b1, 3'b101, 1'b0, 8'd0}) begin
      errors++; $display("FAIL good_frame got v=%b d=%b pe=%b cnt=%0d want v=1 d=101 pe=0 cnt=0", ov_e, od_e, pe_e, cnt_e);
    end
    checks++; if (busy_e !== 1'b0) begin
      errors++; $display("FAIL good_busy_fall got %b want 0", busy_e);
    end
    checks++; if ({ov_o, pe_o, cnt_o} !== {1'b1, 1'b1, 8'd1}) begin
      errors++; $display("FAIL good_odd_view got v=%b pe=%b cnt=%0d want v=1 pe=1 cnt=1", ov_o, pe_o, cnt_o);
    end
    idle(1);
    checks++; if ({ov_e, od_e, pe_e} !== {1'b0, 3'b101, 1'b0}) begin
      errors++; $display("FAIL good_hold got v=%b d=%b pe=%b want v=0 d=101 pe=0", ov_e, od_e, pe_e);
    end
    $display("good: data=%b perr=%b cnt=%0d", od_e, pe_e, cnt_e);
  endtask

  task automatic test_bad_parity;
    logic fe;
    send_frame(3'b110, 1'b1, 0, fe);
    checks++; if ({ov_e, od_e, pe_e, cnt_e} !== {1'b1, 3'b110, 1'b1, 8'd1}) begin
      errors++; $display("FAIL bad_frame got v=%b d=%b pe=%b cnt=%0d want v=1 d=110 pe=1 cnt=1", ov_e, od_e, pe_e, cnt_e);
    end
    for (int i = 0; i < 255; i++) begin
      send_frame(3'($urandom), 1'b0, 0, fe);
      if (m_err_e == 1'b0) send_frame(m_data, 1'b1, 0, fe);
      checks++; if ({ov_e, pe_e, 32'(cnt_e)} !== {1'b1, 1'b1, 32'(m_cnt_e)}) begin
        errors++; $display("FAIL bad_count[%0d] got v=%b pe=%b cnt=%0d want v=1 pe=1 cnt=%0d", i, ov_e, pe_e, cnt_e, m_cnt_e);
      end
    end
    checks++; if (cnt_e !== 8'hFF) begin
      errors++; $display("FAIL err_count_saturate got %h want ff", cnt_e);
    end
    $display("bad_parity: err_count=%h", cnt_e);
  endtask

  task automatic test_gaps;
    logic [3:0] beats;
    beats = 4'b0110; // data 011, parity 0; sof on first beat
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, beats[i], (i == 3));
      if (i != 0) begin
        for (int g = 0; g < 3; g++) begin
          checks++; if ({busy_e, ov_e} !== 2'b10) begin
            errors++; $display("FAIL gap_busy beat=%0d gap=%0d got busy=%b v=%b want busy=1 v=0", 3 - i, g, busy_e, ov_e);
          end
          idle(1);
        end
      end
    end
    model_frame(3'b011, 1'b0);
    checks++; if ({ov_e, od_e, pe_e} !== {1'b1, 3'b011, 1'b0}) begin
      errors++; $display("FAIL gap_frame got v=%b d=%b pe=%b want v=1 d=011 pe=0", ov_e, od_e, pe_e);
    end
    idle(1);
    checks++; if (ov_e !== 1'b0) begin
      errors++; $display("FAIL gap_single_strobe got %b want 0", ov_e);
    end
    $display("gaps: data=%b perr=%b", od_e, pe_e);
  endtask

  task automatic test_abort;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    checks++; if ({fe_e, ov_e, busy_e} !== 3'b101) begin
      errors++; $display("FAIL abort_pulse got fe=%b v=%b busy=%b want fe=1 v=0 busy=1", fe_e, ov_e, busy_e);
    end
    step(1'b1, 1'b1, 1'b0);
    checks++; if ({fe_e, ov_e} !== 2'b00) begin
      errors++; $display("FAIL abort_one_cycle got fe=%b v=%b want fe=0 v=0", fe_e, ov_e);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    model_frame(3'b011, 1'b0);
    checks++; if ({ov_e, od_e, pe_e, fe_e} !== {1'b1, 3'b011, 1'b0, 1'b0}) begin
      errors++; $display("FAIL abort_restart got v=%b d=%b pe=%b fe=%b want v=1 d=011 pe=0 fe=0", ov_e, od_e, pe_e, fe_e);
    end
    $display("abort: data=%b perr=%b", od_e, pe_e);
  endtask

  task automatic test_reset_mid_frame_odd;
    logic fe;
    int t1, t2;
    logic [2:0] d2;
    logic p2;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if ({ov_e, od_e, pe_e, fe_e, busy_e, cnt_e} !== 15'd0) begin
      errors++; $display("FAIL mid_reset got %h want 0", {ov_e, od_e, pe_e, fe_e, busy_e, cnt_e});
    end
    @(negedge clk);
    rst = 1'b0;
    m_cnt_e = 0;
    m_cnt_o = 0;
    step(1'b1, 1'b0, 1'b0); // a stray parity-position bit must not complete anything
    checks++; if ({ov_e, busy_e} !== 2'b00) begin
      errors++; $display("FAIL mid_reset_discard got v=%b busy=%b want 0 0", ov_e, busy_e);
    end
    send_frame(3'b000, 1'b1, 0, fe);
    t1 = cyc;
    checks++; if ({ov_o, od_o, pe_o, cnt_o} !== {1'b1, 3'b000, 1'b0, 8'd0}) begin
      errors++; $display("FAIL odd_frame got v=%b d=%b pe=%b cnt=%0d want v=1 d=000 pe=0 cnt=0", ov_o, od_o, pe_o, cnt_o);
    end
    d2 = 3'($urandom);
    p2 = 1'($urandom);
    send_frame(d2, p2, 0, fe);
    t2 = cyc;
    checks++; if ({ov_o, od_o, pe_o, fe} !== {1'b1, m_data, m_err_o, 1'b0}) begin
      errors++; $display("FAIL b2b_frame got v=%b d=%b pe=%b fe=%b want v=1 d=%b pe=%b fe=0", ov_o, od_o, pe_o, fe, m_data, m_err_o);
    end
    checks++; if (t2 - t1 !== 4) begin
      errors++; $display("FAIL b2b_spacing got %0d want 4", t2 - t1);
    end
    $display("odd/b2b: spacing=%0d cnt_o=%0d", t2 - t1, cnt_o);
  endtask

  task automatic test_random;
    logic fe;
    logic abort;
    logic [2:0] d;
    logic p;
    for (int i = 0; i < 40; i++) begin
      idle($urandom_range(0, 2));
      abort = ($urandom_range(0, 4) == 0);
      if (abort) begin
        step(1'b1, 1'($urandom), 1'b1);
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) step(1'b1, 1'($urandom), 1'b0);
      end
      d = 3'($urandom);
      p = 1'($urandom);
      send_frame(d, p, $urandom_range(0, 1), fe);
      checks++; if ({fe, ov_e, od_e, pe_e, 32'(cnt_e), ov_o, od_o, pe_o, 32'(cnt_o)} !==
                    {abort, 1'b1, d, m_err_e, 32'(m_cnt_e), 1'b1, d, m_err_o, 32'(m_cnt_o)}) begin
        errors++;
        $display("FAIL random[%0d] got fe=%b ve=%b de=%b pe=%b ce=%0d vo=%b do=%b po=%b co=%0d want fe=%b v=1 d=%b pe=%b ce=%0d po=%b co=%0d",
                 i, fe, ov_e, od_e, pe_e, cnt_e, ov_o, od_o, pe_o, cnt_o, abort, d, m_err_e, m_cnt_e, m_err_o, m_cnt_o);
      end
      $display("random[%0d]: abort=%b data=%b par=%b perr_e=%b perr_o=%b", i, abort, d, p, pe_e, pe_o);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_parity();
    test_gaps();
    test_abort();
    test_reset_mid_frame_odd();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
